fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter: ADDR_W, 4, program counter / instruction-memory address width.
REQ-002 Parameter: INSTR_W, 8, instruction width; [7:4] opcode, [3:0] immediate.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 run  input  1  level; 1 = fetch/execute continuously, 0 = stop at next instruction boundary.
REQ-006 pc  output  ADDR_W  address to instruction memory.
REQ-007 instruction  input  INSTR_W  combinational read data for the current pc.
REQ-008 ir  output  INSTR_W  instruction register.
REQ-009 imm  output  4  ir[3:0].
REQ-010 ld_en  output  1  strobe: load imm into the accumulator (LDI).
REQ-011 alu_en  output  1  strobe: ALU operation valid.
REQ-012 alu_op  output  2  00 ADD, 01 SUB, other values reserved.
REQ-013 illegal  output  1  strobe: undefined opcode executed.
REQ-014 halted  output  1  sequencer in HALT state.
REQ-015 retired  output  8  count of executed instructions.

Function
REQ-016 The FSM SHALL have states IDLE, FETCH, EXECUTE and HALT, encoded in a shared enum.
REQ-017 IDLE: run=1 -> FETCH; otherwise stay in IDLE.
REQ-018 FETCH: ir <= instruction, pc <= pc+1 modulo 2^ADDR_W (15 wraps to 0), then -> EXECUTE.
REQ-019 EXECUTE SHALL last exactly one cycle, and the strobes SHALL be asserted only in that cycle, decoded from ir and state with no combinational path from the instruction input.
REQ-020 Opcode 0000 (NOP): no strobe asserted.
REQ-021 Opcode 0001 (LDI): ld_en=1.
REQ-022 Opcode 0010 (ADD): alu_en=1, alu_op=00.
REQ-023 Opcode 0011 (SUB): alu_en=1, alu_op=01.
REQ-024 Opcode 0100 (JMP): pc <= imm at the end of EXECUTE, overriding the FETCH increment; no strobe asserted.
REQ-025 Any other opcode SHALL assert illegal=1, have no other effect, and still count as retired.
REQ-026 After EXECUTE: -> HALT if the halt condition holds (REQ-033); else -> FETCH if run=1; else -> IDLE.
REQ-027 retired SHALL increment by 1 at the end of every EXECUTE cycle, wrapping 255 -> 0.
REQ-028 Throughput SHALL be 2 cycles per instruction; the first strobe appears 3 cycles after run rises in IDLE.
REQ-029 run deasserting during FETCH SHALL NOT abort the instruction in flight; it completes EXECUTE, then the FSM goes to IDLE.
REQ-030 HALT SHALL be sticky: halted=1, no strobes, pc/ir/retired frozen; only rst leaves HALT.

Reset
REQ-031 rst=1 SHALL immediately force state=IDLE, pc=0, ir=0, retired=0, all strobes=0 and halted=0, including mid-FETCH or mid-EXECUTE.
REQ-032 After rst deasserts, the first fetch SHALL read address 0.

Configuration
REQ-033 With macro FETCH_SEQ_HALT_EN defined, opcode 1111 (HALT) SHALL move the FSM to HALT after its EXECUTE cycle; with the macro undefined, 1111 SHALL behave as an illegal opcode (REQ-025), and halted SHALL be tied to 0.

Structure
REQ-034 A shared package SHALL hold the opcode constants, the alu_op encodings, the FSM state enum and the field positions for opcode/imm.
REQ-035 One sub-module, fetch_decoder, SHALL be used: combinational ir+state -> ld_en, alu_en, alu_op, illegal, jump, halt_req; all registers stay in fetch_sequencer.

Verification
REQ-036 Program LDI 5, LDI 3, ADD, SUB, NOP with run=1 -> ld_en in cycles 3 and 5 with imm 5 then 3, alu_en/op 00 in cycle 7, alu_en/op 01 in cycle 9, retired=5 after cycle 11.
REQ-037 JMP 2 at address 4, run held -> pc sequence 0,1,2,3,4,5 then 2; no strobe in the JMP EXECUTE cycle.
REQ-038 Sixteen NOPs, run held -> pc wraps 15 -> 0; retired=16.
REQ-039 run dropped during the FETCH of address 2 -> that instruction still executes, then IDLE with pc=3; run reasserted -> the fetch resumes at 3.
REQ-040 With FETCH_SEQ_HALT_EN, 1111 at address 1 -> halted=1, pc=2 frozen, retired=2; without the macro, illegal pulses once and execution continues.
REQ-041 rst pulsed during EXECUTE of an ADD -> alu_en drops immediately, pc=0, retired=0, state=IDLE.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared opcode, ALU-op and field definitions plus the sequencer state enum.
package fetch_sequencer_pkg;

  localparam int unsigned OPC_W    = 4;
  localparam int unsigned IMM_W    = 4;
  localparam int unsigned ALU_OP_W = 2;

  localparam int unsigned OPC_MSB = 7;
  localparam int unsigned OPC_LSB = 4;
  localparam int unsigned IMM_MSB = 3;
  localparam int unsigned IMM_LSB = 0;

  localparam logic [OPC_W-1:0] OPC_NOP  = 4'h0;
  localparam logic [OPC_W-1:0] OPC_LDI  = 4'h1;
  localparam logic [OPC_W-1:0] OPC_ADD  = 4'h2;
  localparam logic [OPC_W-1:0] OPC_SUB  = 4'h3;
  localparam logic [OPC_W-1:0] OPC_JMP  = 4'h4;
  localparam logic [OPC_W-1:0] OPC_HALT = 4'hF;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 2'b00;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_EXECUTE = 2'd2,
    S_HALT    = 2'd3
  } state_e;

endpackage

// File: rtl/fetch_decoder.sv
// Combinational decode of the instruction register, gated by the EXECUTE state.
// HALT opcode is decoded only when FETCH_SEQ_HALT_EN is defined.
module fetch_decoder
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned INSTR_W = 8
) (
  input  logic [INSTR_W-1:0]  ir,
  input  state_e              state,
  output logic                ld_en_c,
  output logic                alu_en_c,
  output logic [ALU_OP_W-1:0] alu_op_c,
  output logic                illegal_c,
  output logic                jump_c,
  output logic                halt_req_c,
  output logic [IMM_W-1:0]    target_c
);

  logic [OPC_W-1:0] opcode;

  assign opcode   = ir[OPC_MSB:OPC_LSB];
  assign target_c = ir[IMM_MSB:IMM_LSB];

  // Strobes exist only while executing; everything else sees all-zero
  always_comb begin
    ld_en_c    = 1'b0;
    alu_en_c   = 1'b0;
    alu_op_c   = '0;
    illegal_c  = 1'b0;
    jump_c     = 1'b0;
    halt_req_c = 1'b0;
    if (state == S_EXECUTE) begin
      case (opcode)
        OPC_NOP: ;
        OPC_LDI: ld_en_c = 1'b1;
        OPC_ADD: begin
          alu_en_c = 1'b1;
          alu_op_c = ALU_ADD;
        end
        OPC_SUB: begin
          alu_en_c = 1'b1;
          alu_op_c = ALU_SUB;
        end
        OPC_JMP: jump_c = 1'b1;
`ifdef FETCH_SEQ_HALT_EN
        OPC_HALT: halt_req_c = 1'b1;
`else
        OPC_HALT: illegal_c = 1'b1;
`endif
        default: illegal_c = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Two-cycle fetch/execute sequencer with jump, retire counter and optional HALT.
// Define FETCH_SEQ_HALT_EN to enable the sticky HALT opcode (1111).
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned INSTR_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  output logic [ADDR_W-1:0]   pc,
  input  logic [INSTR_W-1:0]  instruction,
  output logic [INSTR_W-1:0]  ir,
  output logic [IMM_W-1:0]    imm,
  output logic                ld_en,
  output logic                alu_en,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                illegal,
  output logic                halted,
  output logic [7:0]          retired
);

  state_e           state_q;
  state_e           state_d;
  logic             jump_c;
  logic             halt_req_c;
  logic [IMM_W-1:0] target_c;

  // Strobes come from registered ir and state only, so reset clears them at once
  fetch_decoder #(
    .INSTR_W (INSTR_W)
  ) u_decoder (
    .ir         (ir),
    .state      (state_q),
    .ld_en_c    (ld_en),
    .alu_en_c   (alu_en),
    .alu_op_c   (alu_op),
    .illegal_c  (illegal),
    .jump_c     (jump_c),
    .halt_req_c (halt_req_c),
    .target_c   (target_c)
  );

  assign imm = ir[IMM_MSB:IMM_LSB];

`ifdef FETCH_SEQ_HALT_EN
  assign halted = (state_q == S_HALT);
`else
  assign halted = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (run) state_d = S_FETCH;
      S_FETCH:   state_d = S_EXECUTE;
      S_EXECUTE: begin
        if (halt_req_c) begin
          state_d = S_HALT;
        end else if (run) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath registers; HALT and IDLE leave them untouched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= '0;
      ir      <= '0;
      retired <= '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          ir <= instruction;
          pc <= pc + ADDR_W'(1);
        end
        S_EXECUTE: begin
          retired <= retired + 8'(1);
          if (jump_c) pc <= ADDR_W'(target_c);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; cycle k is the interval ending at the k-th
// rising edge after reset release, and outputs are sampled on the falling edge.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [3:0] pc;
  logic [7:0] instruction;
  logic [7:0] ir;
  logic [3:0] imm;
  logic       ld_en;
  logic       alu_en;
  logic [1:0] alu_op;
  logic       illegal;
  logic       halted;
  logic [7:0] retired;

  logic [7:0] mem [16];
  int         n_checks = 0;
  int         n_errors = 0;

  fetch_sequencer #(
    .ADDR_W  (4),
    .INSTR_W (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .pc          (pc),
    .instruction (instruction),
    .ir          (ir),
    .imm         (imm),
    .ld_en       (ld_en),
    .alu_en      (alu_en),
    .alu_op      (alu_op),
    .illegal     (illegal),
    .halted      (halted),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  assign instruction = mem[pc];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic strobes(input string tag, input logic l, input logic a, input logic i);
    check({tag, "_ld"},  32'(ld_en),   32'(l));
    check({tag, "_alu"}, 32'(alu_en),  32'(a));
    check({tag, "_ill"}, 32'(illegal), 32'(i));
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    run = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    run = 1'b0;
    clear_mem();
    repeat (2) @(negedge clk);
    check("rst_pc",      32'(pc),          32'h0);
    check("rst_ir",      32'(ir),          32'h0);
    check("rst_retired", 32'(retired),     32'h0);
    check("rst_halted",  32'(halted),      32'h0);
    check("rst_state",   32'(dut.state_q), 32'(S_IDLE));
    strobes("rst", 1'b0, 1'b0, 1'b0);

    // LDI 5, LDI 3, ADD, SUB, NOP
    mem[0] = 8'h15; mem[1] = 8'h13; mem[2] = 8'h20; mem[3] = 8'h30; mem[4] = 8'h00;
    reset_dut();
    run = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      strobes($sformatf("prog_c%0d", c), (c == 3 || c == 5), (c == 7 || c == 9), 1'b0);
      if (c == 3) check("prog_imm5", 32'(imm), 32'h5);
      if (c == 5) check("prog_imm3", 32'(imm), 32'h3);
      if (c == 7) check("prog_add",  32'(alu_op), 32'(ALU_ADD));
      if (c == 9) check("prog_sub",  32'(alu_op), 32'(ALU_SUB));
      step();
    end
    check("prog_retired", 32'(retired), 32'd5);

    // JMP 2 at address 4
    clear_mem();
    mem[4] = 8'h42;
    reset_dut();
    run = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      if (c % 2 == 0 && c <= 10) check($sformatf("jmp_pc_c%0d", c), 32'(pc), 32'(c / 2 - 1));
      if (c == 11) begin
        check("jmp_pc5", 32'(pc), 32'h5);
        check("jmp_ir",  32'(ir), 32'h42);
        strobes("jmp_exec", 1'b0, 1'b0, 1'b0);
      end
      if (c == 12) check("jmp_pc_target", 32'(pc), 32'h2);
      step();
    end

    // Sixteen NOPs: pc wraps
    clear_mem();
    reset_dut();
    run = 1'b1;
    repeat (30) step();
    check("wrap_pc15", 32'(pc), 32'hF);
    repeat (2) step();
    check("wrap_pc0",  32'(pc), 32'h0);
    check("wrap_ret15", 32'(retired), 32'd15);
    step();
    check("wrap_ret16", 32'(retired), 32'd16);

    // run dropped during FETCH of address 2
    clear_mem();
    mem[2] = 8'h17; mem[3] = 8'h30;
    reset_dut();
    run = 1'b1;
    repeat (5) step();
    check("stop_fetch_state", 32'(dut.state_q), 32'(S_FETCH));
    check("stop_fetch_pc",    32'(pc), 32'h2);
    run = 1'b0;
    step();
    strobes("stop_exec", 1'b1, 1'b0, 1'b0);
    check("stop_exec_imm", 32'(imm), 32'h7);
    step();
    check("stop_idle_state", 32'(dut.state_q), 32'(S_IDLE));
    check("stop_idle_pc",    32'(pc), 32'h3);
    check("stop_idle_ret",   32'(retired), 32'd3);
    repeat (2) step();
    check("stop_hold_pc", 32'(pc), 32'h3);
    strobes("stop_hold", 1'b0, 1'b0, 1'b0);
    run = 1'b1;
    step();
    check("resume_state", 32'(dut.state_q), 32'(S_FETCH));
    check("resume_pc",    32'(pc), 32'h3);
    step();
    strobes("resume_exec", 1'b0, 1'b1, 1'b0);
    check("resume_op", 32'(alu_op), 32'(ALU_SUB));
    check("resume_ir", 32'(ir), 32'h30);
    check("resume_pc4", 32'(pc), 32'h4);

    // Opcode 1111 at address 1
    clear_mem();
    mem[1] = 8'hF0; mem[2] = 8'h19;
    reset_dut();
    run = 1'b1;
    repeat (4) step();
`ifdef FETCH_SEQ_HALT_EN
    strobes("halt_exec", 1'b0, 1'b0, 1'b0);
    check("halt_exec_halted", 32'(halted), 32'h0);
    step();
    check("halt_halted", 32'(halted), 32'h1);
    check("halt_pc",     32'(pc), 32'h2);
    check("halt_ret",    32'(retired), 32'd2);
    repeat (4) step();
    check("halt_sticky",     32'(halted), 32'h1);
    check("halt_pc_frozen",  32'(pc), 32'h2);
    check("halt_ret_frozen", 32'(retired), 32'd2);
    check("halt_ir_frozen",  32'(ir), 32'hF0);
    strobes("halt_quiet", 1'b0, 1'b0, 1'b0);
`else
    strobes("f_exec", 1'b0, 1'b0, 1'b1);
    check("f_halted", 32'(halted), 32'h0);
    step();
    check("f_ill_once", 32'(illegal), 32'h0);
    step();
    strobes("f_next", 1'b1, 1'b0, 1'b0);
    check("f_next_imm", 32'(imm), 32'h9);
    check("f_next_ret", 32'(retired), 32'd2);
    check("f_next_halted", 32'(halted), 32'h0);
`endif

    // rst pulsed during EXECUTE of ADD
    clear_mem();
    mem[1] = 8'h20;
    reset_dut();
    run = 1'b1;
    repeat (4) step();
    check("mid_alu_on", 32'(alu_en), 32'h1);
    check("mid_pc",     32'(pc), 32'h2);
    check("mid_ret",    32'(retired), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("mid_alu_off", 32'(alu_en), 32'h0);
    check("mid_rst_pc",  32'(pc), 32'h0);
    check("mid_rst_ret", 32'(retired), 32'h0);
    check("mid_rst_ir",  32'(ir), 32'h0);
    check("mid_rst_state", 32'(dut.state_q), 32'(S_IDLE));
    mem[0] = 8'h1A;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) step();
    strobes("after_rst", 1'b1, 1'b0, 1'b0);
    check("after_rst_imm", 32'(imm), 32'hA);
    check("after_rst_pc",  32'(pc), 32'h1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
